// File: rtl/steer_en_hyst.sv
// rtl/steer_en_hyst.sv - rider-detect and steering-enable controller with hysteresis and settle timer
module steer_en_hyst #(
    parameter int LD_W         = 12,
    parameter int TMR_W        = 26,
    parameter int FAST_SIM     = 1,
    parameter int FAST_TMR_W   = 15,
    parameter int MIN_WEIGHT   = 'h200,
    parameter int HYST         = 'h020,
    parameter int SETTLE_SHIFT = 2,
    parameter int OFF_NUM      = 15,
    parameter int OFF_SHIFT    = 4,
    parameter int OFF_CNT      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_vld,
    input  logic [LD_W-1:0]        lft_ld,
    input  logic [LD_W-1:0]        rght_ld,
    output logic                   en_steer,
    output logic                   rider_off,
    output logic signed [LD_W:0]   ld_cell_diff,
    output logic [LD_W:0]          ld_sum
);

    localparam int SUM_W = LD_W + 1;
    localparam int TE    = (FAST_SIM != 0) ? FAST_TMR_W : TMR_W;
    localparam int NUM_W = $clog2(OFF_NUM + 1);
    localparam int EXT_W = (OFF_SHIFT > NUM_W) ? OFF_SHIFT : NUM_W;
    localparam int CMP_W = SUM_W + EXT_W;
    localparam int CNT_W = $clog2(OFF_CNT + 1);

    localparam logic [SUM_W-1:0] ON_TH   = SUM_W'(MIN_WEIGHT);
    localparam logic [SUM_W-1:0] OFF_TH  = SUM_W'(MIN_WEIGHT - HYST);
    localparam logic [CMP_W-1:0] NUM_C   = CMP_W'(OFF_NUM);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OFF_CNT);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(OFF_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic               clr_tmr;

    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   diff;
    logic [LD_W-1:0]    abs_diff;
    logic [CMP_W-1:0]   abs_scaled;
    logic [CMP_W-1:0]   sum_scaled;
    logic               present;
    logic               low;
    logic               unsettled;
    logic               stepoff;
    logic               off_hit;

    logic [TE-1:0]      tmr;
    logic               tmr_full;
    logic [CNT_W-1:0]   off_cnt;

    assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff = {1'b0, lft_ld} - {1'b0, rght_ld};

    // Subtracting in the direction given by the sign keeps |diff| within LD_W bits
    assign abs_diff = diff[LD_W] ? (rght_ld - lft_ld) : (lft_ld - rght_ld);

    assign abs_scaled = CMP_W'(abs_diff) << OFF_SHIFT;
    assign sum_scaled = CMP_W'(sum) * NUM_C;

    assign present   = (sum >= ON_TH);
    assign low       = (sum < OFF_TH);
    assign unsettled = ({1'b0, abs_diff} > (sum >> SETTLE_SHIFT));
    assign stepoff   = (abs_scaled > sum_scaled);
    assign off_hit   = low && (off_cnt == CNT_HIT);

    assign tmr_full = &tmr;

    always_comb begin
        nxt_state = state;
        clr_tmr   = 1'b0;
        if (ld_vld) begin
            case (state)
                IDLE: begin
                    if (present) begin
                        nxt_state = WAIT;
                        clr_tmr   = 1'b1;
                    end
                end
                WAIT: begin
                    if (off_hit) begin
                        nxt_state = IDLE;
                    end else if (unsettled) begin
                        clr_tmr = 1'b1;
                    end else if (tmr_full) begin
                        nxt_state = STEER;
                    end
                end
                STEER: begin
                    if (off_hit) begin
                        nxt_state = IDLE;
                    end else if (stepoff) begin
                        nxt_state = WAIT;
                        clr_tmr   = 1'b1;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state     <= nxt_state;
            en_steer  <= (nxt_state == STEER);
            rider_off <= (nxt_state == IDLE);
        end
    end

    // Saturating so a long gap in ld_vld cannot wrap past tmr_full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (clr_tmr) begin
            tmr <= '0;
        end else if (!tmr_full) begin
            tmr <= tmr + TE'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_cnt <= '0;
        end else if (nxt_state != state) begin
            off_cnt <= '0;
        end else if (ld_vld) begin
            if (!low) begin
                off_cnt <= '0;
            end else if (off_cnt != CNT_MAX) begin
                off_cnt <= off_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_sum       <= '0;
            ld_cell_diff <= '0;
        end else if (ld_vld) begin
            ld_sum       <= sum;
            ld_cell_diff <= $signed(diff);
        end
    end

endmodule

// File: tb/tb_steer_en_hyst.sv
// tb/tb_steer_en_hyst.sv - self-checking bench for steer_en_hyst against an integer reference model
module tb_steer_en_hyst;

    localparam int TE   = 10;
    localparam int TMAX = (1 << TE) - 1;
    localparam int ON_TH  = 'h200;
    localparam int OFF_TH = 'h200 - 'h020;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ld_vld = 1'b0;
    logic [11:0]        lft_ld = '0;
    logic [11:0]        rght_ld = '0;
    logic               en_steer;
    logic               rider_off;
    logic signed [12:0] ld_cell_diff;
    logic [12:0]        ld_sum;

    int n_vec = 0;
    int n_err = 0;

    // reference model: mode 0 = idle, 1 = waiting to settle, 2 = steering
    int m_mode, m_tmr, m_cnt, m_sum, m_diff;

    steer_en_hyst #(.FAST_SIM(1), .FAST_TMR_W(TE)) dut (
        .clk(clk), .rst(rst), .ld_vld(ld_vld), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .en_steer(en_steer), .rider_off(rider_off),
        .ld_cell_diff(ld_cell_diff), .ld_sum(ld_sum)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0; m_tmr = 0; m_cnt = 0; m_sum = 0; m_diff = 0;
    endfunction

    function automatic void model_step(input bit v, input int l, input int r);
        int s, d, a, nm;
        bit present, low, unsettled, stepoff, hit, clr;
        s = l + r;
        d = l - r;
        a = (d < 0) ? -d : d;
        present   = (s >= ON_TH);
        low       = (s < OFF_TH);
        unsettled = (a > s / 4);
        stepoff   = (a * 16 > s * 15);
        hit       = low && (m_cnt == 3);
        nm  = m_mode;
        clr = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                if (present) begin nm = 1; clr = 1'b1; end
            end else if (hit) begin
                nm = 0;
            end else if (m_mode == 1) begin
                if (unsettled) clr = 1'b1;
                else if (m_tmr == TMAX) nm = 2;
            end else if (stepoff) begin
                nm = 1; clr = 1'b1;
            end
            m_sum  = s;
            m_diff = d;
        end
        m_tmr = clr ? 0 : ((m_tmr < TMAX) ? m_tmr + 1 : TMAX);
        if (nm != m_mode) m_cnt = 0;
        else if (v) m_cnt = low ? ((m_cnt < 4) ? m_cnt + 1 : 4) : 0;
        m_mode = nm;
    endfunction

    task automatic cyc(input bit v, input int l, input int r);
        @(negedge clk);
        ld_vld  = v;
        lft_ld  = 12'(l);
        rght_ld = 12'(r);
        @(posedge clk);
        model_step(v, l, r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ld_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic go_steer();
        int n;
        do_reset();
        cyc(1'b1, 'h180, 'h180);
        n = 0;
        while (!en_steer && n < 4 * TMAX) begin
            cyc(1'b1, 'h180, 'h180);
            n++;
        end
        n_vec++;
        if (en_steer !== 1'b1) begin
            n_err++;
            $display("FAIL go_steer_timeout: en_steer=%b after %0d cycles, required 1", en_steer, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; ld_vld = 1'b1; lft_ld = 12'h300; rght_ld = 12'h300;
        repeat (3) @(posedge clk);
        #1;
        n_vec += 4;
        if (en_steer !== 1'b0) begin n_err++; $display("FAIL reset_en_steer: got %b required 0", en_steer); end
        if (rider_off !== 1'b1) begin n_err++; $display("FAIL reset_rider_off: got %b required 1", rider_off); end
        if (ld_cell_diff !== 13'h0) begin n_err++; $display("FAIL reset_diff: got %h required 0", ld_cell_diff); end
        if (ld_sum !== 13'h0) begin n_err++; $display("FAIL reset_sum: got %h required 0", ld_sum); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 'h300, 'h300);
        n_vec += 3;
        if (rider_off !== 1'b0) begin n_err++; $display("FAIL reset_to_wait_rider_off: got %b required 0", rider_off); end
        if (en_steer !== 1'b0) begin n_err++; $display("FAIL reset_to_wait_en: got %b required 0", en_steer); end
        if (ld_sum !== 13'h600) begin n_err++; $display("FAIL reset_to_wait_sum: got %h required 600", ld_sum); end
    endtask

    task automatic test_mount_settle();
        int n;
        do_reset();
        cyc(1'b1, 'h180, 'h180);
        n_vec++;
        if (rider_off !== 1'b0) begin n_err++; $display("FAIL mount_rider_off: got %b required 0", rider_off); end
        n = 0;
        while (!en_steer && n < 4 * TMAX) begin
            cyc(1'b1, 'h180, 'h180);
            n++;
        end
        n_vec += 2;
        if (n !== TMAX + 1) begin n_err++; $display("FAIL mount_latency: got %0d cycles required %0d", n, TMAX + 1); end
        if (en_steer !== (m_mode == 2)) begin n_err++; $display("FAIL mount_en_model: got %b required %b", en_steer, m_mode == 2); end
    endtask

    task automatic test_unsettled();
        int n, en_seen;
        do_reset();
        cyc(1'b1, 'h180, 'h180);
        en_seen = 0;
        for (int i = 0; i < 3 * TMAX; i++) begin
            cyc(1'b1, 'h300, 'h080);
            if (en_steer) en_seen++;
        end
        n_vec += 2;
        if (en_seen !== 0) begin n_err++; $display("FAIL unsettled_en: got %0d enabled cycles required 0", en_seen); end
        if (rider_off !== 1'b0) begin n_err++; $display("FAIL unsettled_rider_off: got %b required 0", rider_off); end
        n = 0;
        while (!en_steer && n < 4 * TMAX) begin
            cyc(1'b1, 'h1C0, 'h1C0);
            n++;
        end
        n_vec++;
        if (n !== TMAX + 1) begin n_err++; $display("FAIL unsettled_resettle_latency: got %0d required %0d", n, TMAX + 1); end
    endtask

    task automatic test_timer_sat();
        do_reset();
        cyc(1'b1, 'h180, 'h180);
        for (int i = 0; i < 3 * TMAX; i++) cyc(1'b0, 'h000, 'h000);
        n_vec++;
        if (en_steer !== 1'b0) begin n_err++; $display("FAIL sat_hold_en: got %b required 0", en_steer); end
        cyc(1'b1, 'h180, 'h180);
        n_vec++;
        if (en_steer !== 1'b1) begin n_err++; $display("FAIL sat_first_valid_en: got %b required 1", en_steer); end
    endtask

    task automatic test_stepoff();
        go_steer();
        cyc(1'b1, 'h3E0, 'h020);
        n_vec += 2;
        if (en_steer !== 1'b1) begin n_err++; $display("FAIL stepoff_equal_stays: got %b required 1", en_steer); end
        if (ld_cell_diff !== 13'h03C0) begin n_err++; $display("FAIL stepoff_diff: got %h required 03c0", ld_cell_diff); end
        cyc(1'b1, 'h3F0, 'h010);
        n_vec += 2;
        if (en_steer !== 1'b0) begin n_err++; $display("FAIL stepoff_over_en: got %b required 0", en_steer); end
        if (rider_off !== 1'b0) begin n_err++; $display("FAIL stepoff_over_rider_off: got %b required 0", rider_off); end
    endtask

    task automatic test_hysteresis();
        go_steer();
        repeat (5) cyc(1'b1, 'hF8, 'hF8);
        n_vec++;
        if (en_steer !== 1'b1) begin n_err++; $display("FAIL hyst_band_hold: got %b required 1", en_steer); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 'hE8, 'hE8);
            cyc(1'b0, 'hFFF, 'hFFF);
        end
        n_vec++;
        if (ld_sum !== 13'h1D0) begin n_err++; $display("FAIL hyst_gap_hold_sum: got %h required 1d0", ld_sum); end
        cyc(1'b1, 'h100, 'h100);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 'hE8, 'hE8);
            cyc(1'b0, 'h000, 'h000);
        end
        n_vec += 2;
        if (en_steer !== 1'b1) begin n_err++; $display("FAIL hyst_three_low_stays: got %b required 1", en_steer); end
        if (rider_off !== 1'b0) begin n_err++; $display("FAIL hyst_three_low_rider: got %b required 0", rider_off); end
        cyc(1'b1, 'hE8, 'hE8);
        n_vec += 2;
        if (rider_off !== 1'b1) begin n_err++; $display("FAIL hyst_fourth_low_off: got %b required 1", rider_off); end
        if (en_steer !== 1'b0) begin n_err++; $display("FAIL hyst_fourth_low_en: got %b required 0", en_steer); end
    endtask

    task automatic test_width();
        do_reset();
        cyc(1'b1, 'hFFF, 'h000);
        n_vec += 2;
        if (ld_cell_diff !== 13'h0FFF) begin n_err++; $display("FAIL width_pos_diff: got %h required 0fff", ld_cell_diff); end
        if (ld_sum !== 13'h0FFF) begin n_err++; $display("FAIL width_pos_sum: got %h required 0fff", ld_sum); end
        cyc(1'b1, 'h000, 'hFFF);
        n_vec += 2;
        if (ld_cell_diff !== 13'h1001) begin n_err++; $display("FAIL width_neg_diff: got %h required 1001", ld_cell_diff); end
        if (ld_sum !== 13'h0FFF) begin n_err++; $display("FAIL width_neg_sum: got %h required 0fff", ld_sum); end
        go_steer();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec += 4;
        if (en_steer !== 1'b0) begin n_err++; $display("FAIL async_rst_en: got %b required 0", en_steer); end
        if (rider_off !== 1'b1) begin n_err++; $display("FAIL async_rst_rider_off: got %b required 1", rider_off); end
        if (ld_sum !== 13'h0) begin n_err++; $display("FAIL async_rst_sum: got %h required 0", ld_sum); end
        if (ld_cell_diff !== 13'h0) begin n_err++; $display("FAIL async_rst_diff: got %h required 0", ld_cell_diff); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int l, r, base, sel;
        bit v, calm;
        logic [12:0] exp_diff, exp_sum;
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            calm = (blk % 2) == 0;
            for (int i = 0; i < 1200; i++) begin
                v   = ($urandom_range(0, 9) < 8);
                sel = $urandom_range(0, 99);
                base = $urandom_range('hD8, 'h140);
                l = base + $urandom_range(0, 'h20);
                r = base + $urandom_range(0, 'h20);
                if (!calm && sel < 15) begin
                    l = $urandom_range('h200, 'h400);
                    r = $urandom_range(0, 'h80);
                end else if (!calm && sel < 25) begin
                    l = $urandom_range(0, 'hFFF);
                    r = $urandom_range(0, 'hFFF);
                end
                cyc(v, l, r);
                exp_diff = 13'(m_diff);
                exp_sum  = 13'(m_sum);
                n_vec += 4;
                if (en_steer !== (m_mode == 2)) begin n_err++; $display("FAIL rand_en_steer[%0d]: got %b required %b", i, en_steer, m_mode == 2); end
                if (rider_off !== (m_mode == 0)) begin n_err++; $display("FAIL rand_rider_off[%0d]: got %b required %b", i, rider_off, m_mode == 0); end
                if (ld_cell_diff !== exp_diff) begin n_err++; $display("FAIL rand_diff[%0d]: got %h required %h", i, ld_cell_diff, exp_diff); end
                if (ld_sum !== exp_sum) begin n_err++; $display("FAIL rand_sum[%0d]: got %h required %h", i, ld_sum, exp_sum); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mount_settle();
        test_unsettled();
        test_timer_sat();
        test_stepoff();
        test_hysteresis();
        test_width();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
